// File: rtl/verificador_contador_if.sv
// Counter test bus: stimulus into the 16-bit mode counter and its returned outputs.
// master = generator plus counter side; slave = the monitor that only observes.
interface verificador_contador_if;
  logic        enb;
  logic [15:0] D;
  logic [1:0]  modo;
  logic [15:0] Q;
  logic [3:0]  RCO;

  modport master (output enb, D, modo, Q, RCO);
  modport slave  (input  enb, D, modo, Q, RCO);
endinterface

// File: rtl/verificador_contador.sv
// Golden-model monitor for the 16-bit mode counter: syncs on a load, then compares Q/RCO every clock.
// Latency: err/err_count update one cycle after the compare edge; backpressure: none, purely observing.
module verificador_contador #(
  parameter int ERR_W = 8,
  parameter int OK_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  verificador_contador_if.slave bus,
  output logic                 synced,
  output logic                 err,
  output logic [ERR_W-1:0]     err_count,
  output logic [OK_W-1:0]      ok_count,
  output logic [15:0]          first_err_q,
  output logic [15:0]          first_err_exp
);

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] q_exp, q_nxt;
  logic [3:0]  rco_exp, rco_nxt;
  logic [15:0] low, mask;
  logic        load_req, cmp_en, upd_en, mismatch, x_in, x_pend;

  assign load_req = (bus.enb == 1'b1) && (bus.modo == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == SYNC && load_req) state_nxt = TRACK;
  end

  always_comb begin
    synced = 1'b0;
    cmp_en = 1'b0;
    upd_en = 1'b0;
    if (state == TRACK) begin
      synced = 1'b1;
      cmp_en = 1'b1;
      upd_en = 1'b1;
    end else begin
      upd_en = load_req;
    end
  end

  // Next model state; each rco bit looks at the old low bits up to its nibble.
  always_comb begin
    q_nxt   = q_exp;
    rco_nxt = '0;
    low     = '0;
    mask    = '0;
    if (bus.enb == 1'b1) begin
      case (bus.modo)
        2'b00:   q_nxt = q_exp + 16'd1;
        2'b01:   q_nxt = q_exp - 16'd1;
        2'b10:   q_nxt = q_exp - 16'd3;
        default: q_nxt = bus.D;
      endcase
      for (int i = 0; i < 4; i++) begin
        mask = 16'hFFFF >> (12 - 4 * i);
        low  = q_exp & mask;
        case (bus.modo)
          2'b00:   rco_nxt[i] = (low == mask);
          2'b01:   rco_nxt[i] = (low == 16'd0);
          2'b10:   rco_nxt[i] = (low < 16'd3);
          default: rco_nxt[i] = 1'b0;
        endcase
      end
    end
  end

  // Unknown model inputs poison the next compare instead of silently matching.
  assign x_in     = $isunknown({bus.enb, bus.modo}) || (load_req && $isunknown(bus.D));
  assign mismatch = x_pend || (bus.Q !== q_exp) || (bus.RCO !== rco_exp);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_exp         <= '0;
      rco_exp       <= '0;
      x_pend        <= 1'b0;
      err           <= 1'b0;
      err_count     <= '0;
      ok_count      <= '0;
      first_err_q   <= '0;
      first_err_exp <= '0;
    end else begin
      if (upd_en) begin
        q_exp   <= q_nxt;
        rco_exp <= rco_nxt;
      end
      x_pend <= cmp_en && x_in;
      err    <= cmp_en && mismatch;
      if (cmp_en) begin
        if (mismatch) begin
          if (err_count == '0) begin
            first_err_q   <= bus.Q;
            first_err_exp <= q_exp;
          end
          if (err_count != '1) err_count <= err_count + 1'b1;
        end else if (ok_count != '1) begin
          ok_count <= ok_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/verificador_contador.md
# verificador_contador

Synthesizable self-checking monitor for the 16-bit mode counter. It sits on the same buses the stimulus generator drives (enb, D, modo) and the counter returns (Q, RCO). It runs a cycle-accurate golden model of the counter, compares it against the DUT every clock, and reports errors, counts and the first failing value. It is the receiving end of the counter test interface, and it can be placed in a synthesized bench next to the counter.

## Interface
- ERR_W, 8: width of the saturating error counter.
- OK_W, 16: width of the saturating match counter.
- clk  in  1  system clock; everything samples on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enb  in  1  counter enable, as driven to the DUT.
- D  in  16  parallel load value, as driven to the DUT.
- modo  in  2  counter mode, as driven to the DUT.
- Q  in  16  DUT count output.
- RCO  in  4  DUT ripple-carry outputs, one per nibble stage.
- synced  out  1  the model has been aligned to the DUT by a load.
- err  out  1  one-cycle pulse on a mismatch.
- err_count  out  ERR_W  mismatches seen; saturates at all-ones.
- ok_count  out  OK_W  matching compared cycles; saturates at all-ones.
- first_err_q  out  16  DUT Q captured at the first mismatch.
- first_err_exp  out  16  model Q at the first mismatch.

## Operation
- Counter behaviour modelled (edge n, enb=1, evaluated on old q):
  - modo 00: q+1.
  - modo 01: q-1.
  - modo 10: q-3.
  - modo 11: load D.
  - Arithmetic is mod 2^16, so wrap-around is legal, not an error.
- enb=0: q holds and rco becomes 0000.
- rco[i] is registered with q. Let L = q[4i+3:0], the old value of the low bits up to and including nibble i.
  - modo 00: rco[i] = (L == all ones).
  - modo 01: rco[i] = (L == 0).
  - modo 10: rco[i] = (L < 3).
  - modo 11: rco = 0000.
- State machine, states SYNC and TRACK:
  - SYNC (reset state): no compares. The model loads on any edge with enb=1 and modo=11, then moves to TRACK. Otherwise it stays in SYNC.
  - TRACK: the model updates every edge per the rules above. On the same edge, registered Q and RCO are compared against the model state produced by the previous edge.
  - There is no return to SYNC except through reset.
- Mismatch (Q≠q_exp or RCO≠rco_exp, either term X-free):
  - err=1 for one cycle.
  - err_count increments.
  - first_err_q and first_err_exp are captured only if err_count was 0 before this increment.
- Match: ok_count increments.
- Saturation: both counters hold at max, and a mismatch still pulses err while err_count stays at max.

## Timing
- Reset values: synced=0, err=0, err_count=0, ok_count=0, first_err_q=0, first_err_exp=0. Model state q_exp=0 and rco_exp=0.
- Reset is sampled only on the clock edge. Asserted mid-TRACK, it clears everything on that edge and returns to SYNC; the next load re-syncs.
- synced rises on the edge that performs the syncing load.
- Comparison latency: the first compare happens on the edge after the sync edge. DUT outputs must be settled before that edge, since gate delays are allowed up to one period.
- err is asserted the cycle after the compare edge, together with the updated err_count.
- Simultaneous events: a load in TRACK is both an update and a compare edge. The compare uses the model state from before the load; the load sets the new expectation.
- modo/enb X or Z while in SYNC: ignored. In TRACK, X on a model input counts as a mismatch at the next compare.

## Test plan
- Reset, then enb=1, modo=11, D=0000, then modo=00 for 5 cycles with a correct DUT -> synced=1 after the load, ok_count=5, err_count=0, err never high.
- Load D=FFFE, then modo=00 for 3 cycles -> expected Q sequence FFFF, 0000, 0001; rco_exp=1111 exactly on the cycle that produces 0000; no errors.
- Load D=0002, then modo=10 once -> q_exp=FFFF, rco_exp=1111. Injected DUT Q=FFFE -> err pulses once, err_count=1, first_err_q=FFFE, first_err_exp=FFFF.
- enb=0 for 4 cycles with the DUT frozen at 1234 -> q_exp=1234, rco_exp=0000, ok_count +4; a DUT RCO glitch to 0001 in that window -> err_count +1.
- Two injected mismatches with Q=0A0A then 0B0B -> err_count=2, first_err_q remains 0A0A.
- Reset asserted mid-TRACK with err_count=3 -> all outputs 0, synced=0, and no compares until the next modo=11 load.
